display_scan_decoder: RTL and testbench
=======================================

Name: display_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 8-digit 7-segment driver.
- Samples the anode-select and cathode-pattern buses, waits for each digit to settle, and decodes each glyph back to a BCD digit.
- Assembles a full 8-digit scan frame and outputs the two 4-digit values as binary numbers.
- Used for loopback self-check of the display path and for reading scores off a second board's display bus.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured (>=2).
- TIMEOUT_CYCLES, 2097152: cycles with no capture before the frame is abandoned and the link is declared dead.

Ports:
- clock_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- anode_activate  input  8  active-low digit select; bit7 = digit 0 … bit0 = digit 7.
- LED_out  input  8  active-low cathodes; bits[7:1] = segments a..g, bit0 = dp (ignored).
- number1  output  16  binary value of digits 0-3 (digit 0 = thousands).
- number2  output  16  binary value of digits 4-7 (digit 4 = thousands).
- frame_valid  output  1  one-cycle pulse when number1/number2 update.
- frame_error  output  1  one-cycle pulse when a completed frame contained an undecodable glyph.
- link_alive  output  1  high once a valid frame is seen; low after timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; synchronizers, stability counter, slot registers, seen/error masks and timeout counter cleared.
  - State = IDLE.
- Input path: anode_activate and LED_out each pass through a 2-flop synchronizer before any use.
- Stability detection:
  - A pair register holds the previous synchronized {anode, cathode}.
  - If the current pair differs from it, the stability counter resets to 0 and the captured flag clears.
  - Otherwise the counter increments, saturating.
  - Capture fires exactly once per stable pair, when the counter reaches STABLE_CYCLES-1 and the captured flag is clear.
- Anode validity: exactly one bit must be 0. All-ones (blanked) and multi-low patterns are never captured.
- Digit index: the position of the 0 bit, giving 01111111→0 through 11111110→7.
- Glyph decode on LED_out[7:1]. Byte values below are LED_out hex with dp=1:
  - 03→0, 9F→1, 25→2, 0D→3, 99→4, 49→5, 41→6, 1F→7, 01→8, 09→9.
  - Any other pattern stores digit 0 and sets that slot's error bit.
- Capture action:
  - Write the digit into slot[idx]; set seen[idx].
  - error[idx] = glyph invalid.
  - Reset the timeout counter.
  - Recapturing an already-seen slot overwrites it; the latest value wins.
- FSM:
  - IDLE: link_alive=0. A capture moves to COLLECT.
  - COLLECT: when seen==8'hFF, move to EMIT.
  - COLLECT: when the timeout counter reaches TIMEOUT_CYCLES-1, clear seen/error, drive link_alive=0, move to IDLE.
  - EMIT (1 cycle), error==0:
    - number1 = d0*1000 + d1*100 + d2*10 + d3; number2 likewise from d4-d7.
    - Pulse frame_valid; set link_alive=1.
  - EMIT (1 cycle), error!=0: numbers hold their value; pulse frame_error.
  - EMIT always clears seen and error, then returns to COLLECT.
- Latency: output registers and pulses occur 1 cycle after the capture that completes the mask.
- Width: maximum value 9999 fits in 16 bits; zero-extend.
- Simultaneous events:
  - Capture and timeout in the same cycle: the capture wins and the timeout counter resets.
  - A capture in the EMIT cycle is held off until the pair's next stable count. The captured flag stays clear, so capture fires one cycle later in COLLECT.
- The timeout counter runs in COLLECT only and holds 0 in IDLE.
- Reset mid-frame: the partial frame is discarded; number1/number2 return to 0.

Optional Feature:
- Macro ERR_COUNT_EN.
- Defined: adds output error_count [7:0]. Reset 0. Increments on each frame_error pulse and saturates at 255.
- Undefined: the port and counter are absent; frame_error behaviour is unchanged.

Test Plan:
All scenarios use STABLE_CYCLES=4, TIMEOUT_CYCLES=64, and each digit held 20 cycles.
- Scan 1234/5678 (anodes 7F..FE, glyphs 9F,25,0D,99,49,41,1F,01) → one frame_valid pulse, number1=16'h04D2, number2=16'h162E, link_alive=1.
- Same scan, but digit 5's glyph replaced by FF → frame_error pulse, no frame_valid, numbers hold prior values; error_count=1 with ERR_COUNT_EN.
- Insert a 2-cycle glitch (anode DF, glyph 03) between digits → no capture; next full scan of 0000/0009 gives number2=9 and number1=0.
- Drive anode 3F (two digits low) or FF for 40 cycles → no capture, no pulses, seen mask unchanged.
- Scan digits 0-4 then hold anode FF for 64 cycles → link_alive drops to 0 at timeout; a following full 9999/0001 scan gives number1=9999, number2=1.
- Assert reset=0 after 6 digits → outputs 0 immediately; release, full scan 0042/0100 → number1=42, number2=100.

Source files
------------

// File: rtl/display_scan_decoder.sv
// Decodes a multiplexed 8-digit 7-segment display bus into two 4-digit binary values.
// Optional: define ERR_COUNT_EN to add a saturating error_count output.
module display_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [7:0]  anode_activate,
  input  logic [7:0]  LED_out,
  output logic [15:0] number1,
  output logic [15:0] number2,
  output logic        frame_valid,
  output logic        frame_error,
`ifdef ERR_COUNT_EN
  output logic [7:0]  error_count,
`endif
  output logic        link_alive
);

  localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t            state;
  logic [7:0]        anode_meta, anode_sync, led_meta, led_sync;
  logic [15:0]       pair_prev;
  logic [STAB_W-1:0] stable_cnt;
  logic              captured;
  logic [3:0]        slot [8];
  logic [7:0]        seen, err;
  logic [TO_W-1:0]   timeout_cnt;

  logic              pair_same, anode_ok, glyph_ok, capture;
  logic [2:0]        digit_idx;
  logic [3:0]        glyph_digit;
  logic [3:0]        slot_next [8];
  logic [7:0]        seen_next, err_next;

  function automatic logic [15:0] to_bin(input logic [3:0] d3, input logic [3:0] d2,
                                         input logic [3:0] d1, input logic [3:0] d0);
    return 16'(d3) * 16'd1000 + 16'(d2) * 16'd100 + 16'(d1) * 16'd10 + 16'(d0);
  endfunction

  assign pair_same = ({anode_sync, led_sync} == pair_prev);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    anode_ok  = 1'b1;
    digit_idx = 3'd0;
    case (anode_sync)
      8'h7F:   digit_idx = 3'd0;
      8'hBF:   digit_idx = 3'd1;
      8'hDF:   digit_idx = 3'd2;
      8'hEF:   digit_idx = 3'd3;
      8'hF7:   digit_idx = 3'd4;
      8'hFB:   digit_idx = 3'd5;
      8'hFD:   digit_idx = 3'd6;
      8'hFE:   digit_idx = 3'd7;
      default: anode_ok  = 1'b0;
    endcase
  end

  // Table is written as full bytes with the decimal point forced off.
  always_comb begin
    glyph_ok    = 1'b1;
    glyph_digit = 4'd0;
    case ({led_sync[7:1], 1'b1})
      8'h03:   glyph_digit = 4'd0;
      8'h9F:   glyph_digit = 4'd1;
      8'h25:   glyph_digit = 4'd2;
      8'h0D:   glyph_digit = 4'd3;
      8'h99:   glyph_digit = 4'd4;
      8'h49:   glyph_digit = 4'd5;
      8'h41:   glyph_digit = 4'd6;
      8'h1F:   glyph_digit = 4'd7;
      8'h01:   glyph_digit = 4'd8;
      8'h09:   glyph_digit = 4'd9;
      default: glyph_ok    = 1'b0;
    endcase
  end

  // EMIT suppresses capture; the flag stays clear so it fires on the next cycle.
  assign capture = pair_same && (stable_cnt == STAB_MAX) && !captured && anode_ok &&
                   (state != EMIT);

  // Post-capture view of the frame, so the completing digit is emitted without delay.
  always_comb begin
    for (int i = 0; i < 8; i++) slot_next[i] = slot[i];
    seen_next = seen;
    err_next  = err;
    if (capture) begin
      slot_next[digit_idx] = glyph_digit;
      seen_next[digit_idx] = 1'b1;
      err_next[digit_idx]  = !glyph_ok;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      anode_meta <= '0;
      anode_sync <= '0;
      led_meta   <= '0;
      led_sync   <= '0;
      pair_prev  <= '0;
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      anode_meta <= anode_activate;
      anode_sync <= anode_meta;
      led_meta   <= LED_out;
      led_sync   <= led_meta;
      pair_prev  <= {anode_sync, led_sync};
      if (!pair_same) begin
        stable_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        if (stable_cnt != STAB_MAX) stable_cnt <= stable_cnt + STAB_W'(1);
        if (capture) captured <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      number1     <= '0;
      number2     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      link_alive  <= 1'b0;
      seen        <= '0;
      err         <= '0;
      timeout_cnt <= '0;
      // NOTE: the slot array is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < 8; i++) slot[i] <= '0;
`ifdef ERR_COUNT_EN
      error_count <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (capture) begin
        for (int i = 0; i < 8; i++) slot[i] <= slot_next[i];
        seen <= seen_next;
        err  <= err_next;
      end
      case (state)
        IDLE: begin
          link_alive  <= 1'b0;
          timeout_cnt <= '0;
          if (capture) state <= COLLECT;
        end
        COLLECT: begin
          if (capture) begin
            timeout_cnt <= '0;
            if (seen_next == 8'hFF) begin
              state <= EMIT;
              if (err_next == 8'h00) begin
                number1     <= to_bin(slot_next[0], slot_next[1], slot_next[2], slot_next[3]);
                number2     <= to_bin(slot_next[4], slot_next[5], slot_next[6], slot_next[7]);
                frame_valid <= 1'b1;
                link_alive  <= 1'b1;
              end else begin
                frame_error <= 1'b1;
`ifdef ERR_COUNT_EN
                if (error_count != 8'hFF) error_count <= error_count + 8'd1;
`endif
              end
            end
          end else if (timeout_cnt == TO_MAX) begin
            seen        <= '0;
            err         <= '0;
            timeout_cnt <= '0;
            link_alive  <= 1'b0;
            state       <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        EMIT: begin
          seen        <= '0;
          err         <= '0;
          timeout_cnt <= '0;
          state       <= COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_display_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  anode;
  logic [7:0]  led;
  logic [15:0] number1, number2;
  logic        frame_valid, frame_error, link_alive;
`ifdef ERR_COUNT_EN
  logic [7:0]  error_count;
`endif

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int fv_base, fe_base;

  logic [7:0] glyph [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  always #5 clk = ~clk;

  display_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clock_100Mhz  (clk),
    .reset         (reset),
    .anode_activate(anode),
    .LED_out       (led),
    .number1       (number1),
    .number2       (number2),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
`ifdef ERR_COUNT_EN
    .error_count   (error_count),
`endif
    .link_alive    (link_alive)
  );

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] l, input int n);
    anode = a;
    led   = l;
    hold(n);
  endtask

  // Scans positions first..last of n1/n2; bad_pos gets a blank (undecodable) glyph.
  task automatic scan(input int n1, input int n2, input int first, input int last,
                      input int bad_pos);
    int d [8];
    logic [7:0] a;
    d[0] = n1 / 1000; d[1] = (n1 / 100) % 10; d[2] = (n1 / 10) % 10; d[3] = n1 % 10;
    d[4] = n2 / 1000; d[5] = (n2 / 100) % 10; d[6] = (n2 / 10) % 10; d[7] = n2 % 10;
    for (int p = first; p <= last; p++) begin
      a = ~(8'h80 >> p);
      drive(a, (p == bad_pos) ? 8'hFF : glyph[d[p]], 20);
    end
  endtask

  task automatic mark();
    fv_base = fv_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    reset = 1'b0;
    anode = 8'hFF;
    led   = 8'hFF;
    hold(3);
    check("reset_number1", 32'(number1), 32'h0);
    check("reset_number2", 32'(number2), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_link_alive", 32'(link_alive), 32'h0);
    reset = 1'b1;
    hold(2);

    // 1234/5678 with exact latency on the last digit
    mark();
    scan(1234, 5678, 0, 6, -1);
    drive(8'hFE, 8'h01, 6);
    check("t1_fv_before", 32'(frame_valid), 32'h0);
    check("t1_n1_before", 32'(number1), 32'h0);
    hold(1);
    check("t1_fv_pulse", 32'(frame_valid), 32'h1);
    check("t1_number1", 32'(number1), 32'h04D2);
    check("t1_number2", 32'(number2), 32'h162E);
    check("t1_link_alive", 32'(link_alive), 32'h1);
    hold(1);
    check("t1_fv_one_cycle", 32'(frame_valid), 32'h0);
    hold(12);
    check("t1_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("t1_fe_count", 32'(fe_cnt - fe_base), 32'd0);

    // same scan, digit 5 blanked
    mark();
    scan(1234, 5678, 0, 7, 5);
    check("t2_fe_count", 32'(fe_cnt - fe_base), 32'd1);
    check("t2_fv_count", 32'(fv_cnt - fv_base), 32'd0);
    check("t2_number1_hold", 32'(number1), 32'h04D2);
    check("t2_number2_hold", 32'(number2), 32'h162E);
    check("t2_link_alive", 32'(link_alive), 32'h1);
`ifdef ERR_COUNT_EN
    check("t2_error_count", 32'(error_count), 32'd1);
`endif

    // 2-cycle glitch between digits 3 and 4, then 0000/0009
    mark();
    scan(0, 9, 0, 3, -1);
    drive(8'hDF, 8'h03, 2);
    scan(0, 9, 4, 7, -1);
    check("t3_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("t3_fe_count", 32'(fe_cnt - fe_base), 32'd0);
    check("t3_number1", 32'(number1), 32'd0);
    check("t3_number2", 32'(number2), 32'd9);

    // invalid anode patterns
    mark();
    drive(8'h3F, 8'h03, 20);
    drive(8'hFF, 8'hFF, 20);
    check("t4_fv_count", 32'(fv_cnt - fv_base), 32'd0);
    check("t4_fe_count", 32'(fe_cnt - fe_base), 32'd0);
    check("t4_seen", 32'(dut.seen), 32'h0);
    check("t4_link_alive", 32'(link_alive), 32'h1);

    // partial frame then timeout; capture of digit 4 lands 7 edges into its slot
    mark();
    scan(1234, 5000, 0, 4, -1);
    check("t5_alive_pre", 32'(link_alive), 32'h1);
    drive(8'hFF, 8'hFF, 50);
    check("t5_alive_edge", 32'(link_alive), 32'h1);
    hold(1);
    check("t5_alive_timeout", 32'(link_alive), 32'h0);
    hold(13);
    check("t5_pulses", 32'((fv_cnt - fv_base) + (fe_cnt - fe_base)), 32'd0);
    check("t5_number2_hold", 32'(number2), 32'd9);
    mark();
    scan(9999, 1, 0, 7, -1);
    check("t5_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("t5_number1", 32'(number1), 32'd9999);
    check("t5_number2", 32'(number2), 32'd1);
    check("t5_link_back", 32'(link_alive), 32'h1);

    // reset mid-frame
    scan(42, 100, 0, 5, -1);
    anode = 8'hFF;
    led   = 8'hFF;
    reset = 1'b0;
    #2;
    check("t6_rst_number1", 32'(number1), 32'h0);
    check("t6_rst_number2", 32'(number2), 32'h0);
    check("t6_rst_link", 32'(link_alive), 32'h0);
    hold(2);
    reset = 1'b1;
    hold(2);
    mark();
    scan(42, 100, 0, 7, -1);
    check("t6_fv_count", 32'(fv_cnt - fv_base), 32'd1);
    check("t6_number1", 32'(number1), 32'd42);
    check("t6_number2", 32'(number2), 32'd100);
    check("t6_link_alive", 32'(link_alive), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
